// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcode/ALUop
// constants, datapath mux selects, exception codes and the decoded-instruction bundle.
package cpu_ctrl_pkg;

  localparam int OP_W    = 5;
  localparam int ALUOP_W = 5;
  localparam int REG_W   = 5;
  localparam int CODE_W  = 32;

  localparam logic [REG_W-1:0] STATUS_REG = 5'd30;
  localparam logic [REG_W-1:0] LINK_REG   = 5'd31;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MDWAIT, MEM, WB} state_t;

  localparam logic [OP_W-1:0] OP_R    = 5'b00000;
  localparam logic [OP_W-1:0] OP_J    = 5'b00001;
  localparam logic [OP_W-1:0] OP_BNE  = 5'b00010;
  localparam logic [OP_W-1:0] OP_JAL  = 5'b00011;
  localparam logic [OP_W-1:0] OP_JR   = 5'b00100;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OP_W-1:0] OP_BLT  = 5'b00110;
  localparam logic [OP_W-1:0] OP_SW   = 5'b00111;
  localparam logic [OP_W-1:0] OP_LW   = 5'b01000;
  localparam logic [OP_W-1:0] OP_SETX = 5'b10101;
  localparam logic [OP_W-1:0] OP_BEX  = 5'b10110;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 5'b00000;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 5'b00001;
  localparam logic [ALUOP_W-1:0] ALU_AND = 5'b00010;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 5'b00011;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 5'b00100;
  localparam logic [ALUOP_W-1:0] ALU_SRA = 5'b00101;
  localparam logic [ALUOP_W-1:0] ALU_MUL = 5'b00110;
  localparam logic [ALUOP_W-1:0] ALU_DIV = 5'b00111;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_TARGET = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  localparam logic [1:0] WD_ALU    = 2'd0;
  localparam logic [1:0] WD_DMEM   = 2'd1;
  localparam logic [1:0] WD_LINK   = 2'd2;
  localparam logic [1:0] WD_STATUS = 2'd3;

  localparam logic [2:0] CODE_NONE    = 3'd0;
  localparam logic [2:0] CODE_ADD_OVF = 3'd1;
  localparam logic [2:0] CODE_ADDI_OVF = 3'd2;
  localparam logic [2:0] CODE_SUB_OVF = 3'd3;
  localparam logic [2:0] CODE_MUL_EXC = 3'd4;
  localparam logic [2:0] CODE_DIV_EXC = 3'd5;

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               uses_imm;
    logic               writes_rd;
    logic               ovf_type;
    logic [2:0]         ovf_code;
    logic               is_md;
    logic [2:0]         md_code;
    logic               is_lw;
    logic               is_sw;
    logic               is_j;
    logic               is_jal;
    logic               is_jr;
    logic               is_bne;
    logic               is_blt;
    logic               is_bex;
    logic               is_setx;
    logic [REG_W-1:0]   rd;
    logic [CODE_W-1:0]  target;
  } dec_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction-class decode of the registered IR; unknown opcodes and
// unknown R-type ALUops leave every class flag clear, which the FSM treats as a NOP.
module instr_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output dec_t        dec
);

  logic [OP_W-1:0]    op;
  logic [ALUOP_W-1:0] func;

  assign op   = ir[31:27];
  assign func = ir[6:2];

  always_comb begin
    // NOTE: the whole struct is defaulted first so no opcode path leaves a field unassigned (latch).
    dec        = '0;
    dec.rd     = ir[26:22];
    dec.target = {5'd0, ir[26:0]};
    case (op)
      OP_R: begin
        dec.alu_op = func;
        case (func)
          ALU_ADD: begin
            dec.writes_rd = 1'b1;
            dec.ovf_type  = 1'b1;
            dec.ovf_code  = CODE_ADD_OVF;
          end
          ALU_SUB: begin
            dec.writes_rd = 1'b1;
            dec.ovf_type  = 1'b1;
            dec.ovf_code  = CODE_SUB_OVF;
          end
          ALU_AND, ALU_OR, ALU_SLL, ALU_SRA: dec.writes_rd = 1'b1;
          ALU_MUL: begin
            dec.writes_rd = 1'b1;
            dec.is_md     = 1'b1;
            dec.md_code   = CODE_MUL_EXC;
          end
          ALU_DIV: begin
            dec.writes_rd = 1'b1;
            dec.is_md     = 1'b1;
            dec.md_code   = CODE_DIV_EXC;
          end
          default: ;
        endcase
      end
      OP_ADDI: begin
        dec.uses_imm  = 1'b1;
        dec.writes_rd = 1'b1;
        dec.ovf_type  = 1'b1;
        dec.ovf_code  = CODE_ADDI_OVF;
      end
      OP_LW: begin
        dec.uses_imm = 1'b1;
        dec.is_lw    = 1'b1;
      end
      OP_SW: begin
        dec.uses_imm = 1'b1;
        dec.is_sw    = 1'b1;
      end
      OP_BNE: begin
        dec.alu_op = ALU_SUB;
        dec.is_bne = 1'b1;
      end
      OP_BLT: begin
        dec.alu_op = ALU_SUB;
        dec.is_blt = 1'b1;
      end
      OP_J:    dec.is_j    = 1'b1;
      OP_JAL:  dec.is_jal  = 1'b1;
      OP_JR:   dec.is_jr   = 1'b1;
      OP_SETX: dec.is_setx = 1'b1;
      OP_BEX:  dec.is_bex  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MDWAIT/MEM/WB and decodes all
// datapath strobes from the state plus the registered instruction and latched flags.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         instr,
  input  logic                alu_ovf,
  input  logic                alu_neq,
  input  logic                alu_lt,
  input  logic                status_nz,
  input  logic                md_rdy,
  input  logic                md_exc,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          pc_sel,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                alu_inb,
  output logic                md_start,
  output logic                dm_we,
  output logic                rf_we,
  output logic [REG_W-1:0]    rf_wsel,
  output logic [1:0]          rf_wd_sel,
  output logic [CODE_W-1:0]   status_code,
  output logic                instr_done
);

  state_t      state, state_n;
  logic        run;
  logic [31:0] ir;
  logic        ovf_q, exc_q, taken_q;
  logic [2:0]  code;
  logic        wr_req;
  dec_t        dec;

  instr_decode u_decode (
    .ir  (ir),
    .dec (dec)
  );

  // run stays low for the first edge after reset so every output is 0 until FETCH begins.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: non-blocking assignments make every register sample pre-edge values.
    if (!reset) begin
      state <= FETCH;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) state <= state_n;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir      <= '0;
      ovf_q   <= 1'b0;
      exc_q   <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      if (ir_we) ir <= instr;
      if (state == EXEC) begin
        ovf_q   <= alu_ovf;
        exc_q   <= 1'b0;
        taken_q <= (dec.is_bne && alu_neq) || (dec.is_blt && alu_lt) ||
                   (dec.is_bex && status_nz);
      end
      if (state == MDWAIT && md_rdy) exc_q <= md_exc;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      FETCH:  state_n = DECODE;
      DECODE: state_n = EXEC;
      EXEC: begin
        if (dec.is_md)                   state_n = MDWAIT;
        else if (dec.is_lw || dec.is_sw) state_n = MEM;
        else                             state_n = WB;
      end
      MDWAIT: if (md_rdy) state_n = WB;
      MEM:    state_n = dec.is_sw ? FETCH : WB;
      WB:     state_n = FETCH;
      default: state_n = FETCH;
    endcase
  end

  always_comb begin
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = PC_SEQ;
    alu_op      = '0;
    alu_inb     = 1'b0;
    md_start    = 1'b0;
    dm_we       = 1'b0;
    rf_wsel     = '0;
    rf_wd_sel   = WD_ALU;
    status_code = '0;
    instr_done  = 1'b0;
    code        = CODE_NONE;
    wr_req      = 1'b0;
    if (run) begin
      if (state inside {EXEC, MDWAIT, MEM, WB}) begin
        alu_op  = dec.alu_op;
        alu_inb = dec.uses_imm;
      end
      case (state)
        FETCH: ir_we = 1'b1;
        EXEC:  md_start = dec.is_md;
        MEM: begin
          if (dec.is_sw) begin
            dm_we      = 1'b1;
            pc_we      = 1'b1;
            instr_done = 1'b1;
          end
        end
        WB: begin
          pc_we      = 1'b1;
          instr_done = 1'b1;
          if (dec.is_j || dec.is_jal)                   pc_sel = PC_TARGET;
          else if (dec.is_jr)                           pc_sel = PC_REG;
          else if (dec.is_bex && taken_q)               pc_sel = PC_TARGET;
          else if ((dec.is_bne || dec.is_blt) && taken_q) pc_sel = PC_BRANCH;

          // An exception code replaces the instruction's own rd write.
          if (dec.ovf_type && ovf_q)   code = dec.ovf_code;
          else if (dec.is_md && exc_q) code = dec.md_code;

          if (code != CODE_NONE) begin
            wr_req      = 1'b1;
            rf_wsel     = STATUS_REG;
            rf_wd_sel   = WD_STATUS;
            status_code = CODE_W'(code);
          end else if (dec.writes_rd) begin
            wr_req  = 1'b1;
            rf_wsel = dec.rd;
          end else if (dec.is_lw) begin
            wr_req    = 1'b1;
            rf_wsel   = dec.rd;
            rf_wd_sel = WD_DMEM;
          end else if (dec.is_jal) begin
            wr_req    = 1'b1;
            rf_wsel   = LINK_REG;
            rf_wd_sel = WD_LINK;
          end else if (dec.is_setx) begin
            wr_req      = 1'b1;
            rf_wsel     = STATUS_REG;
            rf_wd_sel   = WD_STATUS;
            status_code = dec.target;
          end
        end
        default: ;
      endcase
    end
    rf_we = wr_req && (rf_wsel != '0);
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a driver issues instructions and pushes the
// expected completion record; a monitor pops it whenever instr_done is seen.
module tb_multicycle_ctrl;

  logic        clock, reset;
  logic [31:0] instr;
  logic        alu_ovf, alu_neq, alu_lt, status_nz, md_rdy, md_exc;
  logic        ir_we, pc_we, alu_inb, md_start, dm_we, rf_we, instr_done;
  logic [1:0]  pc_sel, rf_wd_sel;
  logic [4:0]  alu_op, rf_wsel;
  logic [31:0] status_code;
  logic [20:0] outs;

  multicycle_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .instr       (instr),
    .alu_ovf     (alu_ovf),
    .alu_neq     (alu_neq),
    .alu_lt      (alu_lt),
    .status_nz   (status_nz),
    .md_rdy      (md_rdy),
    .md_exc      (md_exc),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .alu_op      (alu_op),
    .alu_inb     (alu_inb),
    .md_start    (md_start),
    .dm_we       (dm_we),
    .rf_we       (rf_we),
    .rf_wsel     (rf_wsel),
    .rf_wd_sel   (rf_wd_sel),
    .status_code (status_code),
    .instr_done  (instr_done)
  );

  assign outs = {ir_we, pc_we, pc_sel, alu_op, alu_inb, md_start, dm_we,
                 rf_we, rf_wsel, rf_wd_sel, instr_done};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         lat;
    logic [1:0] pc_sel;
    logic       wr;
    logic [4:0] wsel;
    logic [1:0] wd;
    logic [31:0] code;
    logic       dm;
    int         md;
    logic       alu_chk;
    logic [4:0] alu_op;
    logic       alu_inb;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  int   cyc      = 0;
  int   start_cyc = 0;
  int   md_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: completion record derived directly from the instruction set rules.
  function automatic exp_t model(input logic [31:0] ins, input bit ovf, input bit neq,
                                 input bit lt, input bit snz, input int k, input bit exc);
    exp_t e;
    logic [4:0] op, f, rd;
    logic [31:0] code;
    op = ins[31:27];
    f  = ins[6:2];
    rd = ins[26:22];
    e.lat = 4; e.pc_sel = 2'd0; e.wr = 1'b0; e.wsel = 5'd0; e.wd = 2'd0; e.code = 32'd0;
    e.dm = 1'b0; e.md = 0; e.alu_chk = 1'b0; e.alu_op = 5'd0; e.alu_inb = 1'b0;
    code = 32'd0;
    if (op == 5'd0 && f <= 5'd7) begin
      e.alu_chk = 1'b1; e.alu_op = f; e.wr = 1'b1; e.wsel = rd;
      if (f == 5'd0 && ovf) code = 32'd1;
      if (f == 5'd1 && ovf) code = 32'd3;
      if (f >= 5'd6) begin
        e.md  = 1;
        e.lat = 5 + k;
        if (exc) code = (f == 5'd6) ? 32'd4 : 32'd5;
      end
    end else if (op == 5'd5) begin
      e.alu_chk = 1'b1; e.alu_inb = 1'b1; e.wr = 1'b1; e.wsel = rd;
      if (ovf) code = 32'd2;
    end else if (op == 5'd8) begin
      e.alu_chk = 1'b1; e.alu_inb = 1'b1; e.lat = 5; e.wr = 1'b1; e.wsel = rd; e.wd = 2'd1;
    end else if (op == 5'd7) begin
      e.alu_chk = 1'b1; e.alu_inb = 1'b1; e.dm = 1'b1;
    end else if (op == 5'd2 || op == 5'd6) begin
      e.alu_chk = 1'b1; e.alu_op = 5'd1;
      e.pc_sel = ((op == 5'd2) ? neq : lt) ? 2'd1 : 2'd0;
    end else if (op == 5'd1) begin
      e.pc_sel = 2'd2;
    end else if (op == 5'd3) begin
      e.pc_sel = 2'd2; e.wr = 1'b1; e.wsel = 5'd31; e.wd = 2'd2;
    end else if (op == 5'd4) begin
      e.pc_sel = 2'd3;
    end else if (op == 5'd21) begin
      e.wr = 1'b1; e.wsel = 5'd30; e.wd = 2'd3; e.code = {5'd0, ins[26:0]};
    end else if (op == 5'd22) begin
      e.pc_sel = snz ? 2'd2 : 2'd0;
    end
    if (code != 32'd0) begin
      e.wsel = 5'd30; e.wd = 2'd3; e.code = code;
    end
    return e;
  endfunction

  function automatic logic [31:0] r_ins(input logic [4:0] f, input logic [4:0] rd);
    return {5'd0, rd, 5'd1, 5'd2, 5'd0, f, 2'b00};
  endfunction

  function automatic logic [31:0] i_ins(input logic [4:0] op, input logic [4:0] rd);
    return {op, rd, 5'd1, 17'h00010};
  endfunction

  function automatic logic [31:0] t_ins(input logic [4:0] op, input logic [26:0] t);
    return {op, t};
  endfunction

  // Waits for FETCH, drives one instruction and its flags, and plays the multdiv handshake.
  task automatic issue(input logic [31:0] ins, input bit ovf, input bit neq, input bit lt,
                       input bit snz, input int k, input bit exc, input bit early);
    exp_t e;
    int   n = 0;
    while (ir_we !== 1'b1) begin
      if (n >= 30) begin
        check("fetch_wait_timeout", 32'(ir_we), 32'd1);
        return;
      end
      @(negedge clock);
      n++;
    end
    instr = ins; alu_ovf = ovf; alu_neq = neq; alu_lt = lt; status_nz = snz;
    md_rdy = 1'b0; md_exc = 1'b0;
    e = model(ins, ovf, neq, lt, snz, k, exc);
    sb_q.push_back(e);
    @(negedge clock);
    if (e.md != 0) begin
      @(negedge clock);
      md_rdy = early; md_exc = early;
      for (int i = 0; i < k; i++) begin
        @(negedge clock);
        md_rdy = 1'b0; md_exc = 1'b0;
      end
      @(negedge clock);
      md_rdy = 1'b1; md_exc = exc;
      @(negedge clock);
      md_rdy = 1'b0; md_exc = 1'b0;
    end
  endtask

  task automatic issue_random();
    logic [31:0] r, ins;
    logic [4:0]  op, rd, f;
    r = $urandom();
    case ($urandom_range(0, 15))
      0, 1, 2, 3: op = 5'd0;
      4:  op = 5'd1;
      5:  op = 5'd2;
      6:  op = 5'd3;
      7:  op = 5'd4;
      8:  op = 5'd5;
      9:  op = 5'd6;
      10: op = 5'd7;
      11: op = 5'd8;
      12: op = 5'd21;
      13: op = 5'd22;
      default: begin
        case ($urandom_range(0, 3))
          0: op = 5'd9;
          1: op = 5'd15;
          2: op = 5'd20;
          default: op = 5'd31;
        endcase
      end
    endcase
    rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    ins = {op, rd, r[21:0]};
    if (op == 5'd0) begin
      f = 5'($urandom_range(0, 9));
      if (f >= 5'd8) f = 5'($urandom_range(8, 31));
      ins[6:2] = f;
    end
    issue(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom_range(0, 6), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      cyc++;
      if (ir_we) begin
        start_cyc = cyc;
        md_cnt    = 0;
      end
      if (md_start) md_cnt++;
      if (cyc == start_cyc + 2 && sb_q.size() > 0 && sb_q[0].alu_chk) begin
        check("exec_alu_op", 32'(alu_op), 32'(sb_q[0].alu_op));
        check("exec_alu_inb", 32'(alu_inb), 32'(sb_q[0].alu_inb));
      end
      check("stray_write", 32'({rf_we, dm_we, pc_we} & {3{~instr_done}}), 32'd0);
      if (instr_done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("latency", 32'(cyc - start_cyc + 1), 32'(e.lat));
          check("pc_we", 32'(pc_we), 32'd1);
          check("pc_sel", 32'(pc_sel), 32'(e.pc_sel));
          check("rf_we", 32'(rf_we), 32'(e.wr && e.wsel != 5'd0));
          check("dm_we", 32'(dm_we), 32'(e.dm));
          check("md_start_cycles", 32'(md_cnt), 32'(e.md));
          if (e.wr) begin
            check("rf_wsel", 32'(rf_wsel), 32'(e.wsel));
            check("rf_wd_sel", 32'(rf_wd_sel), 32'(e.wd));
            if (e.wd == 2'd3) check("status_code", status_code, e.code);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1; instr = '0; alu_ovf = 1'b0; alu_neq = 1'b0; alu_lt = 1'b0;
    status_nz = 1'b0; md_rdy = 1'b0; md_exc = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_outputs", 32'(outs), 32'd0);
    check("reset_status_code", status_code, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("ir_we_after_release", 32'(ir_we), 32'd1);

    // Abort a store while its memory write is pending.
    instr = i_ins(5'd7, 5'd6);
    repeat (3) @(negedge clock);
    check("sw_mem_dm_we", 32'(dm_we), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_writes", 32'({dm_we, pc_we, rf_we}), 32'd0);
    @(negedge clock);
    @(negedge clock);
    check("held_in_reset", 32'(outs), 32'd0);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(negedge clock);
    check("ir_we_after_abort", 32'(ir_we), 32'd1);

    issue(r_ins(5'd0, 5'd3), 1, 0, 0, 0, 0, 0, 0);
    issue(i_ins(5'd8, 5'd5), 0, 0, 0, 0, 0, 0, 0);
    issue(i_ins(5'd5, 5'd0), 0, 0, 0, 0, 0, 0, 0);
    issue(r_ins(5'd7, 5'd9), 0, 0, 0, 0, 3, 1, 1);
    issue(i_ins(5'd2, 5'd4), 0, 1, 0, 0, 0, 0, 0);
    issue(i_ins(5'd2, 5'd4), 0, 0, 0, 0, 0, 0, 0);
    issue(t_ins(5'd3, 27'h0000123), 0, 0, 0, 0, 0, 0, 0);
    issue(t_ins(5'd21, 27'h00ABCDE), 0, 0, 0, 0, 0, 0, 0);
    issue(t_ins(5'd22, 27'h0000040), 0, 0, 0, 1, 0, 0, 0);
    issue(t_ins(5'd31, 27'h0005555), 0, 0, 0, 0, 0, 0, 0);
    issue(i_ins(5'd5, 5'd7), 1, 0, 0, 0, 0, 0, 0);
    issue(r_ins(5'd1, 5'd8), 1, 0, 0, 0, 0, 0, 0);
    issue(r_ins(5'd6, 5'd2), 0, 0, 0, 0, 0, 1, 0);
    issue(i_ins(5'd6, 5'd1), 0, 0, 1, 0, 0, 0, 0);
    issue(i_ins(5'd4, 5'd12), 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 250; i++) issue_random();

    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
